// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage that sits directly in front of a combinational instruction
//   memory. It owns the program counter and registers {instruction, pc} into
//   an IF/ID register that hands off to decode with a valid/ready handshake.
//   A redirect loads a new PC and flushes the IF/ID register. Capturing the
//   halt word freezes fetch until the next redirect.
//
// State table:
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   S_FETCH  | capturing one instruction per cycle whenever IF/ID can take it
//   S_HALTED | halt word captured; pc frozen, only the held word may drain
//
// Ports:
//   clk             in   rising-edge clock
//   rst_n           in   asynchronous active-low reset
//   imem_addr       out  word address to instruction memory (= pc register)
//   imem_data       in   instruction returned combinationally for imem_addr
//   redirect_valid  in   load redirect_target into pc, flush IF/ID
//   redirect_target in   new pc
//   out_valid       out  IF/ID holds a valid instruction
//   out_ready       in   decode accepts the instruction this cycle
//   out_instr       out  fetched instruction
//   out_pc          out  address of out_instr
//   halted          out  fetch is frozen after the halt word
//   fetch_count     out  instructions accepted by decode (wraps)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int                 ADDR_W    = 32,
  parameter int                 DATA_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [ADDR_W-1:0]  PC_STEP   = 1,
  parameter logic [DATA_W-1:0]  HALT_WORD = '1,  // all ones: 32'hFFFF_FFFF
  parameter int                 CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  typedef enum logic [0:0] {
    S_FETCH  = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic              accept;
  logic              capture;
  logic              is_halt;

  assign imem_addr = pc_q;
  assign halted    = (state_q == S_HALTED);
  assign accept    = out_valid & out_ready;
  assign is_halt   = (imem_data == HALT_WORD);
  // IF/ID can take a new word when empty or when its current word leaves now.
  assign capture   = (state_q == S_FETCH) & ~redirect_valid & (~out_valid | out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = S_FETCH;
    end else if (capture && is_halt) begin
      state_d = S_HALTED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_pc      <= '0;
      fetch_count <= '0;
    end else if (redirect_valid) begin
      // Flushed word is never counted, even if decode was ready this cycle.
      pc_q      <= redirect_target;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        fetch_count <= fetch_count + 1'b1;
      end
      if (capture) begin
        out_instr <= imem_data;
        out_pc    <= pc_q;
        out_valid <= 1'b1;
        pc_q      <= pc_q + PC_STEP;  // halt word still advances pc
      end else if (accept) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
